// File: rtl/alu_seq_if.sv
// alu_seq_if: request, result and ALU-drive signals of the ALU sequencing front end
interface alu_seq_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_eqz;
  logic              out_lz;
  modport slave (
    input  in_valid, in_op, in_a, in_b, alu_out, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_eqz, out_lz
  );
  modport master (
    output in_valid, in_op, in_a, in_b, alu_out, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_eqz, out_lz
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one ALU operation per request; shifts run as repeated 1-bit ALU passes
module alu_seq_ctrl #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input logic        clk,
  input logic        rst,
  alu_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                eqz_q, eqz_d, lz_q, lz_d;
  logic                res_ld;
  logic [DATA_W-1:0]   res_nx;
  logic                op_legal, op_shift, in_legal, in_shift;
  assign op_legal = op_q <= 4'd8;
  assign op_shift = op_q >= 4'd6 && op_legal;
  assign in_legal = bus.in_op <= 4'd8;
  assign in_shift = bus.in_op >= 4'd6 && in_legal;
  assign bus.in_ready   = state_q == IDLE;
  assign bus.out_valid  = state_q == DONE;
  assign bus.out_result = result_q;
  assign bus.out_eqz    = eqz_q;
  assign bus.out_lz     = lz_q;
  assign bus.alu_a      = acc_q;
  assign bus.alu_b      = op_shift ? DATA_W'(1) : b_q;
  assign bus.alu_sel    = op_legal ? op_q : 4'd0;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_ld  = 1'b0;
    res_nx  = bus.alu_out;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        op_d  = bus.in_op;
        b_d   = bus.in_b;
        acc_d = bus.in_a;
        cnt_d = bus.in_b[SHAMT_W-1:0];
        if (!in_legal) begin
          res_ld  = 1'b1;
          res_nx  = '0;
          state_d = DONE;
        end else if (in_shift && bus.in_b[SHAMT_W-1:0] == '0) begin
          res_ld  = 1'b1;
          res_nx  = bus.in_a;
          state_d = DONE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: if (op_shift) begin
        acc_d = bus.alu_out;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          res_ld  = 1'b1;
          state_d = DONE;
        end
      end else begin
        res_ld  = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // flags are captured in the same cycle as the result they describe
    result_d = res_ld ? res_nx : result_q;
    eqz_d    = res_ld ? res_nx == '0 : eqz_q;
    lz_d     = res_ld ? res_nx[DATA_W-1] : lz_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      eqz_q    <= 1'b0;
      lz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      eqz_q    <= eqz_d;
      lz_q     <= lz_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench with a behavioural 32-bit ALU attached to the sequencer
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  alu_seq_if bus ();
  alu_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    case (bus.alu_sel)
      4'd0: bus.alu_out = bus.alu_a + bus.alu_b;
      4'd1: bus.alu_out = bus.alu_a ^ bus.alu_b;
      4'd2: bus.alu_out = bus.alu_a - bus.alu_b;
      4'd3: bus.alu_out = ~bus.alu_a;
      4'd4: bus.alu_out = bus.alu_a | bus.alu_b;
      4'd5: bus.alu_out = bus.alu_a & bus.alu_b;
      4'd6: bus.alu_out = bus.alu_a << bus.alu_b[0];
      4'd7: bus.alu_out = $unsigned($signed(bus.alu_a) >>> bus.alu_b[0]);
      4'd8: bus.alu_out = bus.alu_a >> bus.alu_b[0];
      default: bus.alu_out = '0;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] res, input logic eqz, input logic lz, input int hold);
    int cycles = 0;
    logic ready_seen = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".sel"}, 32'(bus.alu_sel), (op <= 4'd8) ? 32'(op) : 32'd0);
    chk({tag, ".alu_b"}, bus.alu_b, (op >= 4'd6 && op <= 4'd8) ? 32'd1 : b);
    while (!bus.out_valid && cycles < 40) begin
      ready_seen |= bus.in_ready;
      @(negedge clk);
      cycles++;
    end
    ready_seen |= bus.in_ready;
    chk({tag, ".lat"}, 32'(cycles), 32'(lat));
    chk({tag, ".busy"}, 32'(ready_seen), 32'd0);
    chk({tag, ".res"}, bus.out_result, res);
    chk({tag, ".flags"}, {30'd0, bus.out_eqz, bus.out_lz}, {30'd0, eqz, lz});
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.in_a = 32'd1; bus.in_b = 32'd1;
      @(negedge clk);
      chk({tag, ".stall"}, {bus.out_result[29:0], bus.out_valid, bus.in_ready}, {res[29:0], 1'b1, 1'b0});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst.hs", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    chk("rst.res", bus.out_result, 32'd0);
    chk("rst.flags", {30'd0, bus.out_eqz, bus.out_lz}, 32'd0);
    chk("rst.alu", bus.alu_a | bus.alu_b | 32'(bus.alu_sel), 32'd0);
    rst = 1'b0;
    run("add",  4'd0, 32'd5,          32'd7,        1,  32'd12,         1'b0, 1'b0, 0);
    run("sub",  4'd2, 32'd3,          32'd5,        1,  32'hFFFFFFFE,   1'b0, 1'b1, 0);
    run("not",  4'd3, 32'hFFFFFFFF,   32'd9,        1,  32'd0,          1'b1, 1'b0, 0);
    run("sla",  4'd6, 32'd1,          32'd31,       31, 32'h80000000,   1'b0, 1'b1, 0);
    run("sra",  4'd7, 32'h80000000,   32'h24,       4,  32'hF8000000,   1'b0, 1'b1, 0);
    run("srl",  4'd8, 32'h80000000,   32'h24,       4,  32'h08000000,   1'b0, 1'b0, 0);
    run("sh0",  4'd6, 32'h1234,       32'd32,       0,  32'h1234,       1'b0, 1'b0, 0);
    run("ill",  4'd12, 32'hDEAD,      32'hBEEF,     0,  32'd0,          1'b1, 1'b0, 0);
    run("bp",   4'd1, 32'hFF,         32'h0F,       1,  32'hF0,         1'b0, 1'b0, 3);
    repeat (2) @(negedge clk);
    chk("bp.noq", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b1; bus.in_op = 4'd8; bus.in_a = 32'hF0000000; bus.in_b = 32'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid.busy", {30'd0, bus.in_ready, bus.out_valid}, 32'b00);
    rst = 1'b1;
    #1;
    chk("mid.hs", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    chk("mid.res", bus.out_result, 32'd0);
    chk("mid.alu", bus.alu_a | bus.alu_b | 32'(bus.alu_sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("mid.nov", {31'd0, bus.out_valid}, 32'd0);
    run("post", 4'd0, 32'd1,          32'd1,        1,  32'd2,          1'b0, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
